// File: rtl/adder_arbiter.sv
// Round-robin arbiter in front of one shared BUS-wide adder: grant, add, hold result until taken.
// Optional ADDER_ARB_OVERFLOW_EN adds a registered signed-overflow flag (rsp_ovf).
module adder_arbiter #(
   parameter int BUS     = 32,
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*BUS-1:0] req_a,
   input  logic [NUM_REQ*BUS-1:0] req_b,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [BUS-1:0]         rsp_data,
   output logic [ID_W-1:0]        rsp_id,
`ifdef ADDER_ARB_OVERFLOW_EN
   output logic                   rsp_ovf,
`endif
   output logic                   busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]      state;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] rr_next;
   logic [BUS-1:0]  op_a;
   logic [BUS-1:0]  op_b;
   logic [ID_W-1:0] op_id;
   logic [BUS-1:0]  sum;
   logic            grant_any;
   logic [ID_W-1:0] grant_idx;
   logic [ID_W:0]   cand;
   logic [BUS-1:0]  sel_a;
   logic [BUS-1:0]  sel_b;

   // Scan from rr_ptr upward with wrap; the extra bit in cand holds rr_ptr+k before folding.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      req_ready = '0;
      cand      = '0;
      if (state == IDLE) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ))
               cand = cand - (ID_W+1)'(NUM_REQ);
            if (!grant_any && req_valid[cand[ID_W-1:0]]) begin
               grant_any = 1'b1;
               grant_idx = cand[ID_W-1:0];
            end
         end
         if (grant_any)
            req_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            sel_a = req_a[i*BUS +: BUS];
            sel_b = req_b[i*BUS +: BUS];
         end
      end
   end

   assign rr_next = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
   assign sum     = op_a + op_b;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         op_a      <= '0;
         op_b      <= '0;
         op_id     <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  op_a   <= sel_a;
                  op_b   <= sel_b;
                  op_id  <= grant_idx;
                  rr_ptr <= rr_next;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               rsp_data  <= sum;
               rsp_id    <= op_id;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ADDER_ARB_OVERFLOW_EN
   // Signed overflow: both operands share a sign that the sum does not.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rsp_ovf <= 1'b0;
      else if (state == EXEC)
         rsp_ovf <= (op_a[BUS-1] == op_b[BUS-1]) && (sum[BUS-1] != op_a[BUS-1]);
   end
`endif

endmodule
